// File: rtl/tqvp_dlmiles_i2c_pkg.sv
// Shared definitions for the TinyQV I2C register front-end.
// Holds register addresses, IRQ bit indices, STATUS field positions,
// the IRQ vector width and the bus write-width decode helper.
package tqvp_dlmiles_i2c_pkg;

   // Register map (byte addresses on the 6-bit peripheral bus)
   localparam logic [5:0] ADDR_DATA       = 6'h00;
   localparam logic [5:0] ADDR_STATUS     = 6'h04;
   localparam logic [5:0] ADDR_IRQ_STATUS = 6'h08;
   localparam logic [5:0] ADDR_IRQ_ENABLE = 6'h0C;
   localparam logic [5:0] ADDR_CTRL       = 6'h10;

   // IRQ vector layout
   localparam int IRQ_W     = 6;
   localparam int IRQ_RXNE  = 0;
   localparam int IRQ_TXE   = 1;
   localparam int IRQ_NACK  = 2;
   localparam int IRQ_ARBL  = 3;
   localparam int IRQ_TXOVF = 4;
   localparam int IRQ_RXOVF = 5;

   // Only these bits are stored; RXNE/TXE are live FIFO levels.
   localparam logic [IRQ_W-1:0] IRQ_STICKY_MASK = 6'b111100;

   // STATUS field positions
   localparam int ST_TX_FULL    = 0;
   localparam int ST_RX_EMPTY   = 1;
   localparam int ST_ENG_BUSY   = 2;
   localparam int ST_RX_LVL_LSB = 4;
   localparam int ST_TX_LVL_LSB = 8;
   localparam int ST_LVL_W      = 4;

   // CTRL bits (self-clearing strobes)
   localparam int CTRL_FLUSH_TX = 0;
   localparam int CTRL_FLUSH_RX = 1;

   // data_write_n encoding used by TinyQV
   typedef enum logic [1:0] {
      ACC_BYTE = 2'b00,
      ACC_HALF = 2'b01,
      ACC_WORD = 2'b10,
      ACC_IDLE = 2'b11
   } access_e;

   // Byte-lane mask of the bytes a write of the given width covers.
   function automatic logic [31:0] write_mask(input logic [1:0] wr_n);
      logic [31:0] m;
      case (access_e'(wr_n))
         ACC_BYTE: m = 32'h0000_00FF;
         ACC_HALF: m = 32'h0000_FFFF;
         ACC_WORD: m = 32'hFFFF_FFFF;
         default:  m = 32'h0000_0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/tqvp_dlmiles_i2c_regif_if.sv
// TinyQV peripheral bus bundle between the CPU side (master) and the
// I2C register front-end (slave).
//   address       6-bit register address
//   data_in       32-bit write data
//   data_write_n  2'b11 idle, else write of byte/half/word
//   data_read_n   2'b11 idle, else a read access lasting exactly one cycle
//   data_out      read data, combinational from address and state
//   data_ready    always 1: every access completes in the cycle it is issued
// Handshake: there is no wait state. A write or read is accepted at the
// clock edge ending the cycle in which its _n strobe is not 2'b11; side
// effects (FIFO push/pop, W1C) happen at that edge exactly once.
interface tqvp_dlmiles_i2c_regif_if;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;

   modport master (
      output address, data_in, data_write_n, data_read_n,
      input  data_out, data_ready
   );

   modport slave (
      input  address, data_in, data_write_n, data_read_n,
      output data_out, data_ready
   );
endinterface

// File: rtl/tqvp_dlmiles_i2c_fifo.sv
// Synchronous FIFO with flush, used for both TX commands and RX bytes.
//   flush_i      empties the FIFO at the next edge; beats push and pop
//   push_i/data  write request; accepted when not full or when a pop
//                with data happens in the same cycle
//   pop_i        read request; ignored when empty
//   head_o       oldest entry (undefined when empty)
//   full_o/empty_o/level_o  occupancy
//   ovf_o        push request dropped because the FIFO was full
module tqvp_dlmiles_i2c_fifo
   import tqvp_dlmiles_i2c_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign do_pop  = pop_i && !empty_o && !flush_i;
   // A full FIFO still accepts a push when the same edge frees a slot.
   assign do_push = push_i && (!full_o || do_pop) && !flush_i;
   assign ovf_o   = push_i && full_o && !do_pop && !flush_i;
   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         // Pointers wrap naturally since DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: level gates every observable use of it.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/tqvp_dlmiles_i2c_regif.sv
// TinyQV bus front-end for the I2C peripheral: register file, TX command
// FIFO, RX data FIFO and maskable level interrupt.
//   clk, rst_n       peripheral clock, async active-low reset
//   bus              TinyQV peripheral bus (slave side)
//   user_interrupt   registered |(IRQ_STATUS & IRQ_ENABLE)
//   tx_valid/ready   TX FIFO head handshake to the byte engine
//   tx_data          {stop, start, payload}
//   rx_valid/rx_data engine byte strobe (no backpressure) and byte
//   eng_busy         engine busy level
//   eng_nack/arb_lost one-cycle event pulses
module tqvp_dlmiles_i2c_regif
   import tqvp_dlmiles_i2c_pkg::*;
#(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4,
   parameter int DATA_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   tqvp_dlmiles_i2c_regif_if.slave bus,
   output logic                    user_interrupt,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [DATA_W+1:0]       tx_data,
   input  logic                    rx_valid,
   input  logic [DATA_W-1:0]       rx_data,
   input  logic                    eng_busy,
   input  logic                    eng_nack,
   input  logic                    eng_arb_lost
);

   localparam int TX_LVL_W = $clog2(TX_DEPTH) + 1;
   localparam int RX_LVL_W = $clog2(RX_DEPTH) + 1;

   logic [31:0]         wdata;
   logic                wr_en, rd_en;
   logic                wr_data, wr_irq_st, wr_irq_en, wr_ctrl, rd_data;
   logic                flush_tx, flush_rx;
   logic                tx_full, tx_empty, tx_ovf;
   logic                rx_full, rx_empty, rx_ovf;
   logic [TX_LVL_W-1:0] tx_level;
   logic [RX_LVL_W-1:0] rx_level;
   logic [DATA_W-1:0]   rx_head;
   logic [IRQ_W-1:0]    sticky_q, sticky_d;
   logic [IRQ_W-1:0]    irq_en_q, irq_en_d;
   logic [IRQ_W-1:0]    irq_set, irq_clr, irq_status;
   logic                irq_q, irq_d;
   logic [31:0]         rd_val;
   logic                unused_bits;

   // Bytes outside the access width are treated as zero.
   assign wdata     = bus.data_in & write_mask(bus.data_write_n);
   assign wr_en     = (bus.data_write_n != 2'b11);
   assign rd_en     = (bus.data_read_n != 2'b11);
   assign wr_data   = wr_en && (bus.address == ADDR_DATA);
   assign wr_irq_st = wr_en && (bus.address == ADDR_IRQ_STATUS);
   assign wr_irq_en = wr_en && (bus.address == ADDR_IRQ_ENABLE);
   assign wr_ctrl   = wr_en && (bus.address == ADDR_CTRL);
   assign rd_data   = rd_en && (bus.address == ADDR_DATA);
   assign flush_tx  = wr_ctrl && wdata[CTRL_FLUSH_TX];
   assign flush_rx  = wr_ctrl && wdata[CTRL_FLUSH_RX];

   tqvp_dlmiles_i2c_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W + 2)) u_tx_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush_tx),
      .push_i     (wr_data),
      .push_data_i(wdata[DATA_W+1:0]),
      .pop_i      (tx_ready),
      .head_o     (tx_data),
      .full_o     (tx_full),
      .empty_o    (tx_empty),
      .level_o    (tx_level),
      .ovf_o      (tx_ovf)
   );

   tqvp_dlmiles_i2c_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush_rx),
      .push_i     (rx_valid),
      .push_data_i(rx_data),
      .pop_i      (rd_data),
      .head_o     (rx_head),
      .full_o     (rx_full),
      .empty_o    (rx_empty),
      .level_o    (rx_level),
      .ovf_o      (rx_ovf)
   );

   assign tx_valid = !tx_empty;

   always_comb begin
      irq_set            = '0;
      irq_set[IRQ_NACK]  = eng_nack;
      irq_set[IRQ_ARBL]  = eng_arb_lost;
      irq_set[IRQ_TXOVF] = tx_ovf;
      irq_set[IRQ_RXOVF] = rx_ovf;
      irq_clr            = wr_irq_st ? wdata[IRQ_W-1:0] : '0;
      // Set after clear so a same-cycle event survives a W1C.
      sticky_d = ((sticky_q & ~irq_clr) | irq_set) & IRQ_STICKY_MASK;
      irq_en_d = wr_irq_en ? wdata[IRQ_W-1:0] : irq_en_q;
      irq_status           = sticky_q;
      irq_status[IRQ_RXNE] = !rx_empty;
      irq_status[IRQ_TXE]  = tx_empty;
      irq_d = |(irq_status & irq_en_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
         irq_en_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign user_interrupt = irq_q;

   always_comb begin
      rd_val = '0;
      case (bus.address)
         ADDR_DATA: begin
            rd_val[DATA_W] = rx_empty;
            if (!rx_empty) rd_val[DATA_W-1:0] = rx_head;
         end
         ADDR_STATUS: begin
            rd_val[ST_TX_FULL]                     = tx_full;
            rd_val[ST_RX_EMPTY]                    = rx_empty;
            rd_val[ST_ENG_BUSY]                    = eng_busy;
            rd_val[ST_RX_LVL_LSB +: ST_LVL_W]      = ST_LVL_W'(rx_level);
            rd_val[ST_TX_LVL_LSB +: ST_LVL_W]      = ST_LVL_W'(tx_level);
         end
         ADDR_IRQ_STATUS: rd_val[IRQ_W-1:0] = irq_status;
         ADDR_IRQ_ENABLE: rd_val[IRQ_W-1:0] = irq_en_q;
         default:         rd_val = '0;
      endcase
   end

   assign bus.data_out   = rd_val;
   assign bus.data_ready = 1'b1;

   assign unused_bits = ^{wdata[31:DATA_W+2], rx_full};

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_regif.sv
// Testbench for tqvp_dlmiles_i2c_regif: directed steps followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_tqvp_dlmiles_i2c_regif;

   localparam int DW  = 8;
   localparam int TXD = 4;
   localparam int RXD = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tqvp_dlmiles_i2c_regif_if bus ();
   logic          tx_valid, tx_ready, rx_valid, eng_busy, eng_nack, eng_arb_lost;
   logic          user_interrupt;
   logic [DW+1:0] tx_data;
   logic [DW-1:0] rx_data;

   tqvp_dlmiles_i2c_regif #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DATA_W(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .user_interrupt(user_interrupt),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_data       (tx_data),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .eng_busy      (eng_busy),
      .eng_nack      (eng_nack),
      .eng_arb_lost  (eng_arb_lost)
   );

   // ---------------- reference model ----------------
   logic [DW+1:0] m_tx[$];
   logic [DW-1:0] m_rx[$];
   logic [5:0]    m_sticky;
   logic [5:0]    m_en;
   logic          m_irq;
   int            vectors     = 0;
   int            miscompares = 0;

   task automatic model_reset();
      m_tx.delete();
      m_rx.delete();
      m_sticky = '0;
      m_en     = '0;
      m_irq    = 1'b0;
   endtask

   function automatic logic [5:0] m_irqstat();
      return {m_sticky[5:2], m_tx.size() == 0, m_rx.size() != 0};
   endfunction

   function automatic logic [31:0] m_read(input logic [5:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         6'h00: v = (m_rx.size() == 0) ? 32'h100 : {24'h0, m_rx[0]};
         6'h04: v = {20'h0, 4'(m_tx.size()), 4'(m_rx.size()), 1'b0, eng_busy,
                     m_rx.size() == 0, m_tx.size() == TXD};
         6'h08: v = {26'h0, m_irqstat()};
         6'h0C: v = {26'h0, m_en};
         default: v = '0;
      endcase
      return v;
   endfunction

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_edge();
      logic [31:0] wd;
      logic        wr, rd, f_tx, f_rx, p_tx, p_rx, o_tx, o_rx, irq_nx;
      logic [5:0]  clr, set;
      case (bus.data_write_n)
         2'b00:   wd = bus.data_in & 32'hFF;
         2'b01:   wd = bus.data_in & 32'hFFFF;
         2'b10:   wd = bus.data_in;
         default: wd = '0;
      endcase
      wr     = (bus.data_write_n != 2'b11);
      rd     = (bus.data_read_n != 2'b11);
      irq_nx = |(m_irqstat() & m_en);
      f_tx   = wr && bus.address == 6'h10 && wd[0];
      f_rx   = wr && bus.address == 6'h10 && wd[1];
      o_tx   = 1'b0;
      o_rx   = 1'b0;
      if (f_tx) m_tx.delete();
      else begin
         p_tx = tx_ready && m_tx.size() != 0;
         if (wr && bus.address == 6'h00 && m_tx.size() == TXD && !p_tx) o_tx = 1'b1;
         if (p_tx) void'(m_tx.pop_front());
         if (wr && bus.address == 6'h00 && !o_tx) m_tx.push_back(wd[DW+1:0]);
      end
      if (f_rx) m_rx.delete();
      else begin
         p_rx = rd && bus.address == 6'h00 && m_rx.size() != 0;
         if (rx_valid && m_rx.size() == RXD && !p_rx) o_rx = 1'b1;
         if (p_rx) void'(m_rx.pop_front());
         if (rx_valid && !o_rx) m_rx.push_back(rx_data);
      end
      clr      = (wr && bus.address == 6'h08) ? wd[5:0] : 6'h00;
      set      = {o_rx, o_tx, eng_arb_lost, eng_nack, 2'b00};
      m_sticky = ((m_sticky & ~clr) | set) & 6'h3C;
      if (wr && bus.address == 6'h0C) m_en = wd[5:0];
      m_irq = irq_nx;
   endtask

   // ---------------- scoreboard check ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: compare outputs mid-cycle, then step DUT and model.
   task automatic step();
      @(negedge clk);
      chk("data_out", bus.data_out, m_read(bus.address));
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_tx.size() != 0});
      if (m_tx.size() != 0) chk("tx_data", {22'b0, tx_data}, {22'b0, m_tx[0]});
      chk("user_interrupt", {31'b0, user_interrupt}, {31'b0, m_irq});
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic bus_idle();
      bus.address      = 6'h00;
      bus.data_in      = 32'h0;
      bus.data_write_n = 2'b11;
      bus.data_read_n  = 2'b11;
   endtask

   task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
      bus.address      = a;
      bus.data_in      = d;
      bus.data_write_n = w;
      step();
      bus_idle();
   endtask

   task automatic bus_rd(input logic [5:0] a, output logic [31:0] v);
      bus.address     = a;
      bus.data_read_n = 2'b10;
      #2;
      v = bus.data_out;
      step();
      bus_idle();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] v;
      logic [9:0]  exp3[3];
      int          op;

      bus_idle();
      tx_ready = 0; rx_valid = 0; rx_data = '0;
      eng_busy = 0; eng_nack = 0; eng_arb_lost = 0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("rst_irq", {31'b0, user_interrupt}, 32'd0);
      chk("rst_data_out", bus.data_out, 32'h100);
      chk("data_ready", {31'b0, bus.data_ready}, 32'd1);
      rst_n = 1'b1;

      bus_rd(6'h04, v);
      chk("rst_tx_level", {28'b0, v[11:8]}, 32'd0);
      chk("rst_rx_level", {28'b0, v[7:4]}, 32'd0);
      chk("rst_rx_empty", {31'b0, v[1]}, 32'd1);
      bus_rd(6'h00, v);
      chk("rst_data_empty", v, 32'h100);

      // TX ordering with backpressure
      exp3[0] = 10'h1A5; exp3[1] = 10'h0C3; exp3[2] = 10'h23C;
      for (int i = 0; i < 3; i++) bus_wr(6'h00, {22'b0, exp3[i]}, 2'b10);
      chk("tx_hold", {22'b0, tx_data}, 32'h1A5);
      step();
      chk("tx_hold2", {22'b0, tx_data}, 32'h1A5);
      tx_ready = 1;
      for (int i = 0; i < 3; i++) begin
         chk("tx_order", {22'b0, tx_data}, {22'b0, exp3[i]});
         step();
      end
      tx_ready = 0;
      chk("tx_drained", {31'b0, tx_valid}, 32'd0);

      // TX overflow and W1C
      for (int i = 0; i < 5; i++) bus_wr(6'h00, $urandom & 32'h3FF, 2'b10);
      bus_rd(6'h04, v);
      chk("tx_level_full", {28'b0, v[11:8]}, 32'd4);
      bus_rd(6'h08, v);
      chk("txovf_set", {31'b0, v[4]}, 32'd1);
      bus_wr(6'h08, 32'h10, 2'b10);
      bus_rd(6'h08, v);
      chk("txovf_clr", {31'b0, v[4]}, 32'd0);

      // RX path and RXNE interrupt timing
      bus_wr(6'h0C, 32'h01, 2'b00);
      rx_valid = 1; rx_data = 8'h55;
      step();
      rx_data = 8'hAA;
      chk("irq_after_1", {31'b0, user_interrupt}, 32'd0);
      step();
      rx_valid = 0;
      chk("irq_after_2", {31'b0, user_interrupt}, 32'd1);
      bus_rd(6'h00, v);
      chk("rx_first", v, 32'h55);
      bus_rd(6'h00, v);
      chk("rx_second", v, 32'hAA);
      chk("irq_hold", {31'b0, user_interrupt}, 32'd1);
      bus_rd(6'h00, v);
      chk("rx_empty_rd", v, 32'h100);
      chk("irq_drop", {31'b0, user_interrupt}, 32'd0);

      // W1C racing a NACK event: set wins
      eng_nack = 1;
      bus_wr(6'h08, 32'h04, 2'b00);
      eng_nack = 0;
      bus_rd(6'h08, v);
      chk("nack_set_wins", {31'b0, v[2]}, 32'd1);
      bus_wr(6'h08, 32'h04, 2'b00);
      bus_rd(6'h08, v);
      chk("nack_cleared", {31'b0, v[2]}, 32'd0);

      // Flush with two queued entries
      bus_wr(6'h10, 32'h1, 2'b10);
      bus_wr(6'h00, 32'h011, 2'b10);
      bus_wr(6'h00, 32'h122, 2'b01);
      bus_wr(6'h10, 32'h1, 2'b00);
      chk("flush_tx_valid", {31'b0, tx_valid}, 32'd0);
      bus_rd(6'h04, v);
      chk("flush_tx_level", {28'b0, v[11:8]}, 32'd0);
      bus_rd(6'h08, v);
      chk("flush_no_ovf", {31'b0, v[4]}, 32'd0);

      // Randomized phase
      for (int i = 0; i < 600; i++) begin
         tx_ready     = 1'($urandom_range(0, 1));
         rx_valid     = ($urandom_range(0, 2) == 0);
         rx_data      = 8'($urandom);
         eng_busy     = 1'($urandom_range(0, 1));
         eng_nack     = ($urandom_range(0, 15) == 0);
         eng_arb_lost = ($urandom_range(0, 15) == 0);
         op           = $urandom_range(0, 9);
         bus_idle();
         case (op)
            0, 1, 2: begin
               bus.address      = 6'h00;
               bus.data_in      = $urandom;
               bus.data_write_n = 2'($urandom_range(0, 2));
            end
            3, 4: begin
               bus.address     = 6'h00;
               bus.data_read_n = 2'($urandom_range(0, 2));
            end
            5: begin
               bus.address     = 6'(4 * $urandom_range(0, 15));
               bus.data_read_n = 2'b10;
            end
            6: begin
               bus.address      = 6'h08;
               bus.data_in      = $urandom;
               bus.data_write_n = 2'($urandom_range(0, 2));
            end
            7: begin
               bus.address      = 6'h0C;
               bus.data_in      = $urandom;
               bus.data_write_n = 2'($urandom_range(0, 2));
            end
            8: begin
               if ($urandom_range(0, 3) == 0) begin
                  bus.address      = 6'h10;
                  bus.data_in      = $urandom;
                  bus.data_write_n = 2'b10;
               end
            end
            default: begin
               bus.address      = 6'(4 * $urandom_range(5, 15));
               bus.data_in      = $urandom;
               bus.data_write_n = 2'b10;
            end
         endcase
         step();
      end
      bus_idle();
      tx_ready = 0; rx_valid = 0; eng_busy = 0; eng_nack = 0; eng_arb_lost = 0;

      // Asynchronous reset in the middle of activity
      bus_wr(6'h0C, 32'h3F, 2'b10);
      bus_wr(6'h00, 32'h123, 2'b10);
      rx_valid = 1; rx_data = 8'h5A;
      step();
      rx_valid = 0;
      step();
      step();
      chk("pre_rst_tx_valid", {31'b0, tx_valid}, 32'd1);
      chk("pre_rst_irq", {31'b0, user_interrupt}, 32'd1);
      tx_ready = 1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("async_rst_irq", {31'b0, user_interrupt}, 32'd0);
      chk("async_rst_data_out", bus.data_out, 32'h100);
      tx_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      bus_rd(6'h04, v);
      chk("post_rst_levels", {24'b0, v[11:4]}, 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
